// File: rtl/lane_hit_detector.sv
// lane_hit_detector: counts white pixels inside NUM_LANES fixed lane windows of a scan band,
// then at each frame boundary reports one hit bit per lane through a valid/ack handshake.
// Optional build macro LANE_DEBOUNCE_EN: a lane only reports a hit when it also hit in the
// previous frame.
module lane_hit_detector #(
   parameter int unsigned NUM_LANES  = 5,
   parameter int unsigned LANE0_X    = 160,
   parameter int unsigned LANE_PITCH = 80,
   parameter int unsigned LANE_WIDTH = 16,
   parameter int unsigned ROW_START  = 400,
   parameter int unsigned ROW_HEIGHT = 8,
   parameter int unsigned HIT_COUNT  = 64,
   parameter int unsigned CNT_W      = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 HSync,
   input  logic                 VSync,
   input  logic                 PixEn,
   input  logic                 Enable,
   input  logic [7:0]           Grey,
   input  logic                 HitsAck,
   output logic [NUM_LANES-1:0] Hits,
   output logic                 HitsValid,
   output logic                 Overrun
);

   typedef enum logic [1:0] {StWaitFrame, StScan, StReport} state_t;

   state_t r_state;
   state_t w_state_next;

   logic r_hs_cur, r_hs_prev, r_vs_cur, r_vs_prev;
   logic w_hs_rise, w_vs_rise;

   logic [10:0] r_x, r_y;
   logic [CNT_W-1:0] r_cnt [NUM_LANES];

   logic [NUM_LANES-1:0] w_in_col;
   logic [NUM_LANES-1:0] w_inc;
   logic [NUM_LANES-1:0] w_raw;
   logic [NUM_LANES-1:0] w_hits_rep;
   logic                 w_in_rows;
   logic                 w_pix_ok;
   logic                 w_unused_grey;

   logic [NUM_LANES-1:0] r_hits;
   logic                 r_valid;
   logic                 r_ovr;

   // Only the MSB of the thresholded pixel carries information.
   assign w_unused_grey = ^Grey[6:0];

   // Sync edge detection: register each sync twice and compare the two stages.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_hs_cur  <= 1'b0;
         r_hs_prev <= 1'b0;
         r_vs_cur  <= 1'b0;
         r_vs_prev <= 1'b0;
      end else begin
         r_hs_cur  <= HSync;
         r_hs_prev <= r_hs_cur;
         r_vs_cur  <= VSync;
         r_vs_prev <= r_vs_cur;
      end
   end

   assign w_hs_rise = r_hs_cur & ~r_hs_prev;
   assign w_vs_rise = r_vs_cur & ~r_vs_prev;

   // Column/row position tracking; a VSync rise clears both, even alongside an HSync rise.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_x <= '0;
         r_y <= '0;
      end else begin
         if (w_vs_rise || w_hs_rise) begin
            r_x <= '0;
         end else if (PixEn && r_x != 11'h7FF) begin
            r_x <= r_x + 11'd1;
         end
         if (w_vs_rise) begin
            r_y <= '0;
         end else if (w_hs_rise && r_y != 11'h7FF) begin
            r_y <= r_y + 11'd1;
         end
      end
   end

   assign w_in_rows = (32'(r_y) >= ROW_START) && (32'(r_y) < ROW_START + ROW_HEIGHT);
   assign w_pix_ok  = (r_state == StScan) && PixEn && Enable && Grey[7] && w_in_rows &&
                      !w_hs_rise && !w_vs_rise;

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      localparam int unsigned ColLo = LANE0_X + k * LANE_PITCH;
      assign w_in_col[k] = (32'(r_x) >= ColLo) && (32'(r_x) < ColLo + LANE_WIDTH);
      assign w_inc[k]    = w_pix_ok && w_in_col[k];
      assign w_raw[k]    = 32'(r_cnt[k]) >= HIT_COUNT;
   end

   // Per-lane saturating white-pixel counters, cleared at each frame start.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int k = 0; k < NUM_LANES; k++) r_cnt[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_LANES; k++) begin
            if ((r_state == StWaitFrame && w_vs_rise) || r_state == StReport) begin
               r_cnt[k] <= '0;
            end else if (w_inc[k] && r_cnt[k] != {CNT_W{1'b1}}) begin
               r_cnt[k] <= r_cnt[k] + 1'b1;
            end
         end
      end
   end

`ifdef LANE_DEBOUNCE_EN
   logic [NUM_LANES-1:0] r_prev_raw;

   // Previous-frame raw hits; forgotten whenever a discarded frame ends.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_prev_raw <= '0;
      end else if (r_state == StWaitFrame && w_vs_rise) begin
         r_prev_raw <= '0;
      end else if (r_state == StReport) begin
         r_prev_raw <= w_raw;
      end
   end

   assign w_hits_rep = w_raw & r_prev_raw;
`else
   assign w_hits_rep = w_raw;
`endif

   // FSM state register.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) r_state <= StWaitFrame;
      else      r_state <= w_state_next;
   end

   // FSM next-state: discard the first frame, then scan and report once per frame.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StWaitFrame: if (w_vs_rise) w_state_next = StScan;
         StScan:      if (w_vs_rise) w_state_next = StReport;
         StReport:    w_state_next = StScan;
         default:     w_state_next = StWaitFrame;
      endcase
   end

   // Report registers and handshake; a new report beats a same-cycle ack.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_hits  <= '0;
         r_valid <= 1'b0;
         r_ovr   <= 1'b0;
      end else if (r_state == StReport) begin
         r_hits  <= w_hits_rep;
         r_valid <= 1'b1;
         if (r_valid && !HitsAck) r_ovr <= 1'b1;
      end else if (r_valid && HitsAck) begin
         r_valid <= 1'b0;
      end
   end

   assign Hits      = r_hits;
   assign HitsValid = r_valid;
   assign Overrun   = r_ovr;

endmodule

// File: tb/tb_lane_hit_detector.sv
// Self-checking bench for lane_hit_detector: table-driven frames plus hand-written
// handshake, reset and debounce sequences; expected reports go through a scoreboard queue.
module tb_lane_hit_detector;

   localparam int P_NONE  = 0;
   localparam int P_ALL   = 1;
   localparam int P_LANE2 = 2;
   localparam int P_LANE0 = 3;
   localparam int P_EDGE  = 4;
   localparam int P_LANE1 = 5;

   logic       CLK = 1'b0;
   logic       RST;
   logic       HSync, VSync, PixEn, Enable, HitsAck;
   logic [7:0] Grey;
   logic [4:0] Hits;
   logic       HitsValid, Overrun;

   int n_checks = 0;
   int n_errors = 0;

   logic       exp_valid, exp_ovr;
   logic [4:0] m_prev;
   logic [4:0] sb_q[$];

   typedef struct {
      string      name;
      int         pat;
      int         n;
      logic       en;
      int         ncols;
      logic [4:0] hits;
   } vec_t;

   vec_t tbl[6];

   lane_hit_detector dut (
      .CLK       (CLK),
      .RST       (RST),
      .HSync     (HSync),
      .VSync     (VSync),
      .PixEn     (PixEn),
      .Enable    (Enable),
      .Grey      (Grey),
      .HitsAck   (HitsAck),
      .Hits      (Hits),
      .HitsValid (HitsValid),
      .Overrun   (Overrun)
   );

   always #5 CLK = ~CLK;

   task automatic cyc();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic is_white(input int pat, input int n, input int x, input int y);
      case (pat)
         P_ALL:   return 1'b1;
         P_LANE2: return x >= 320 && x <= 335 && y >= 400 && y <= 407;
         P_LANE1: return x >= 240 && x <= 255 && y >= 400 && y <= 407;
         P_LANE0: return x >= 160 && x <= 175 && y >= 400 && y <= 407 &&
                         ((y - 400) * 16 + (x - 160)) < n;
         P_EDGE:  return (x == 159 && y == 400) || (x == 176 && y == 400) ||
                         (x == 160 && y == 399) || (x == 160 && y == 408);
         default: return 1'b0;
      endcase
   endfunction

   task automatic do_reset();
      RST = 1'b0;
      #1;
      check("rst_async_hits", 32'(Hits), 32'd0);
      check("rst_async_valid", 32'(HitsValid), 32'd0);
      check("rst_async_overrun", 32'(Overrun), 32'd0);
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
      m_prev    = '0;
      sb_q.delete();
      @(negedge CLK);
      RST = 1'b1;
   endtask

   // One frame: 408 lines, pixels only on rows 399..408; rst_row >= 0 resets mid-row.
   task automatic frame(input int pat, input int n, input logic en, input int ncols,
                        input int rst_row);
      Enable = en;
      for (int y = 1; y <= 408; y++) begin
         HSync = 1'b1;
         PixEn = 1'b0;
         Grey  = 8'($urandom_range(0, 255));
         cyc();
         cyc();
         HSync = 1'b0;
         cyc();
         cyc();
         if (y >= 399) begin
            for (int x = 0; x < ncols; x++) begin
               if (y == rst_row && x == 8) do_reset();
               PixEn = 1'b1;
               if (is_white(pat, n, x, y)) Grey = 8'h80 | 8'($urandom_range(0, 127));
               else                        Grey = 8'($urandom_range(0, 127));
               cyc();
            end
            PixEn = 1'b0;
         end
      end
   endtask

   // Frame boundary; report=1 expects a new report two edges after VSync is sampled.
   task automatic vsync(input logic report, input logic [4:0] raw, input logic ack_rep,
                        input string tag);
      logic [4:0] exp;
      HSync = 1'b0;
      PixEn = 1'b0;
      VSync = 1'b1;
      cyc();
      cyc();
      check({tag, "_valid_edge1"}, 32'(HitsValid), 32'(exp_valid));
      VSync   = 1'b0;
      HitsAck = ack_rep;
      if (report) begin
`ifdef LANE_DEBOUNCE_EN
         exp = raw & m_prev;
`else
         exp = raw;
`endif
         m_prev = raw;
         sb_q.push_back(exp);
         if (exp_valid && !ack_rep) exp_ovr = 1'b1;
         exp_valid = 1'b1;
      end else begin
         m_prev = '0;
      end
      cyc();
      HitsAck = 1'b0;
      check({tag, "_valid_edge2"}, 32'(HitsValid), 32'(exp_valid));
      check({tag, "_overrun"}, 32'(Overrun), 32'(exp_ovr));
      if (report) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_scoreboard: got empty queue, expected one entry", tag);
         end else begin
            exp = sb_q.pop_front();
            check({tag, "_hits"}, 32'(Hits), 32'(exp));
         end
      end
      cyc();
      cyc();
   endtask

   task automatic ack(input string tag);
      HitsAck = 1'b1;
      cyc();
      HitsAck   = 1'b0;
      exp_valid = 1'b0;
      check({tag, "_ack_clears"}, 32'(HitsValid), 32'd0);
   endtask

   initial begin
      tbl[0] = '{"all_white",   P_ALL,   0,  1'b1, 500, 5'b11111};
      tbl[1] = '{"single_lane", P_LANE2, 0,  1'b1, 340, 5'b00100};
      tbl[2] = '{"thresh_63",   P_LANE0, 63, 1'b1, 180, 5'b00000};
      tbl[3] = '{"thresh_64",   P_LANE0, 64, 1'b1, 180, 5'b00001};
      tbl[4] = '{"win_edges",   P_EDGE,  0,  1'b1, 180, 5'b00000};
      tbl[5] = '{"enable_off",  P_ALL,   0,  1'b0, 500, 5'b00000};

      RST = 1'b0;
      HSync = 1'b0;
      VSync = 1'b0;
      PixEn = 1'b0;
      Enable = 1'b1;
      HitsAck = 1'b0;
      Grey = 8'h00;
      exp_valid = 1'b0;
      exp_ovr = 1'b0;
      m_prev = '0;

      repeat (3) @(negedge CLK);
      check("reset_hits", 32'(Hits), 32'd0);
      check("reset_valid", 32'(HitsValid), 32'd0);
      check("reset_overrun", 32'(Overrun), 32'd0);
      RST = 1'b1;
      cyc();

      // Ack with nothing pending is ignored.
      HitsAck = 1'b1;
      cyc();
      HitsAck = 1'b0;
      check("idle_ack_valid", 32'(HitsValid), 32'd0);
      check("idle_ack_overrun", 32'(Overrun), 32'd0);

      // First frame after reset is discarded.
      frame(P_ALL, 0, 1'b1, 500, -1);
      vsync(1'b0, 5'b0, 1'b0, "discard");

      for (int i = 0; i < 6; i++) begin
         frame(tbl[i].pat, tbl[i].n, tbl[i].en, tbl[i].ncols, -1);
         vsync(1'b1, tbl[i].hits, 1'b0, tbl[i].name);
         ack(tbl[i].name);
      end

      // Ack landing in the REPORT cycle: new report wins, no overrun.
      frame(P_LANE0, 64, 1'b1, 180, -1);
      vsync(1'b1, 5'b00001, 1'b0, "ackrep_a");
      frame(P_NONE, 0, 1'b1, 180, -1);
      vsync(1'b1, 5'b00000, 1'b1, "ackrep_b");
      ack("ackrep_b");

      // Two unacked reports: overrun, second frame visible.
      frame(P_LANE0, 64, 1'b1, 180, -1);
      vsync(1'b1, 5'b00001, 1'b0, "ovr_a");
      frame(P_NONE, 0, 1'b1, 180, -1);
      vsync(1'b1, 5'b00000, 1'b0, "ovr_b");

      // Reset in row 403: frame discarded, the following one reports.
      frame(P_LANE2, 0, 1'b1, 340, 403);
      vsync(1'b0, 5'b0, 1'b0, "post_rst_discard");
      frame(P_LANE2, 0, 1'b1, 340, -1);
      vsync(1'b1, 5'b00100, 1'b0, "post_rst_report");
      ack("post_rst_report");

      // Lane 1 in two consecutive frames (debounced build reports only the second).
      frame(P_LANE1, 0, 1'b1, 260, -1);
      vsync(1'b1, 5'b00010, 1'b0, "lane1_n");
      ack("lane1_n");
      frame(P_LANE1, 0, 1'b1, 260, -1);
      vsync(1'b1, 5'b00010, 1'b0, "lane1_n1");
      ack("lane1_n1");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lane_hit_detector.md
Name: lane_hit_detector

Overview:
- Consumer of the filter chain's output stream: takes the thresholded grey pixel, HSync and VSync, and tracks column and row position.
- Counts white pixels inside NUM_LANES fixed rectangular lane windows on every frame.
- At each frame boundary, reports one hit bit per lane to the controller through a valid/ack handshake.
- Sits directly downstream of the greyscale/threshold pipeline and feeds the actuator logic.

Parameters:
NUM_LANES, 5, number of lane windows
LANE0_X, 160, first column of lane 0 window
LANE_PITCH, 80, column offset between adjacent lane windows
LANE_WIDTH, 16, window width in columns
ROW_START, 400, first row of the scan band
ROW_HEIGHT, 8, scan band height in rows
HIT_COUNT, 64, minimum white-pixel count for a lane hit
CNT_W, 8, per-lane counter width (saturating)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-low reset
HSync  in  1  line sync, active high; rising edge starts a new line
VSync  in  1  frame sync, active high; rising edge ends the current frame
PixEn  in  1  pixel qualifier; Grey is valid when high
Enable  in  1  accumulate enable
Grey  in  8  thresholded grey pixel
HitsAck  in  1  controller acknowledge of the current report
Hits  out  NUM_LANES  per-lane hit flags of the last completed frame
HitsValid  out  1  report pending
Overrun  out  1  sticky flag: a report was overwritten before it was acked

Behaviour:
- Reset values while RST=0, asynchronously: Hits=0, HitsValid=0, Overrun=0, all counters 0, state WAIT_FRAME.
- Edge detection: HSync and VSync are registered; a rise is current=1 and previous=0.
- Column counter X (11b):
  - Cleared on an HSync rise; the pixel in that cycle is ignored.
  - Otherwise X increments on each PixEn cycle and saturates at 2047.
  - The pixel in any cycle has column X, using the pre-increment value.
- Row counter Y (11b): increments on an HSync rise, cleared on a VSync rise, saturates at 2047.
- White pixel: Grey[7]=1.
- Lane k window: LANE0_X+k*LANE_PITCH <= X < LANE0_X+k*LANE_PITCH+LANE_WIDTH, and ROW_START <= Y < ROW_START+ROW_HEIGHT.
- Lane counter k increments when all of the following hold; it saturates at 2^CNT_W-1:
  - state=SCAN
  - PixEn=1 and Enable=1
  - the pixel is white and inside window k
  - no HSync or VSync rise in that cycle
- Enable=0 stops accumulation only; X, Y and reporting continue.
- State machine:
  - WAIT_FRAME: entered at reset; discards the partial frame. On a VSync rise, clear the lane counters and go to SCAN with no report.
  - SCAN: accumulate. On a VSync rise, go to REPORT; the pixel in that cycle is not counted.
  - REPORT (one cycle):
    - Hits[k] <= (count_k >= HIT_COUNT).
    - HitsValid <= 1.
    - If HitsValid=1 and HitsAck=0 in this cycle, Overrun <= 1.
    - Clear all lane counters; go to SCAN.
- Latency: Hits and HitsValid update at the second CLK edge after the edge at which VSync is first sampled high.
- Handshake:
  - HitsValid holds until a cycle with HitsAck=1; it clears on the next edge.
  - HitsAck with HitsValid=0 is ignored.
  - HitsAck in the REPORT cycle: the new report wins, HitsValid stays 1, Overrun is not set.
- Hits holds its value until the next REPORT. Overrun clears only on reset.
- HSync and VSync rising in the same cycle: VSync handling takes priority, and both X and Y are cleared.
- Reset mid-frame: all state is lost; the next frame after reset is discarded via WAIT_FRAME.

Optional Feature:
- Macro: LANE_DEBOUNCE_EN.
- Defined:
  - Each lane keeps a registered previous-frame raw hit.
  - Reported Hits[k] = raw hit of this frame AND raw hit of the previous frame.
  - The previous-frame register resets to 0 and clears on a WAIT_FRAME exit.
  - Latency is unchanged.
- Undefined: Hits[k] = raw hit of the current frame; no extra registers.

Test Plan:
- Reset and first frame: release RST, drive a full-white frame, then a VSync rise → no HitsValid; at the second VSync rise HitsValid=1, Hits=5'b11111, Overrun=0.
- Single lane: white only at X 320..335, Y 400..407, then a VSync rise → Hits=5'b00100 with HitsValid asserted exactly 2 edges after VSync is first sampled high.
- Threshold boundary: 63 white pixels in lane 0 → Hits[0]=0; next frame with 64 → Hits[0]=1.
- Window edges: white only at (X,Y) = (159,400), (176,400), (160,399), (160,408) → all counts 0, Hits=0. Repeat with Enable=0 on an all-white frame → Hits=0, report still issued.
- Handshake, no ack: two frames without HitsAck → Overrun=1, Hits shows the second frame. HitsAck in the REPORT cycle → HitsValid stays 1, Overrun stays 0.
- Reset mid-frame: assert RST during row 403 → outputs 0 immediately; the next frame is discarded and the one after reports correctly. With LANE_DEBOUNCE_EN, lane 1 white in frames N and N+1 → Hits[1]=0, then 1.
